element_cmd_sched: RTL

ELEMENT_CMD_SCHED -- requirements
Module: element_cmd_sched

---
 rtl/element_cmd_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/element_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : element_cmd_sched
// Purpose  : Time-stamped command FIFO that issues each command to a pulser
//            element when the free-running time counter reaches its stamp.
//            Optional macro SCHED_LATE_DROP_EN: drop late heads instead of
//            issuing them.
// Revision : 1.0  initial release
// ============================================================================
module element_cmd_sched #(
    parameter int DEPTH = 8,
    parameter int TW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tref_sync,
    input  logic                     flush,
    input  logic [63:0]              in_cmd,
    input  logic [TW-1:0]            in_time,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [63:0]              command,
    output logic                     cstrobe,
    input  logic                     collision,
    input  logic                     stat_clr,
    output logic [TW-1:0]            tnow,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     late,
    output logic [7:0]               coll_cnt
);

    localparam int                c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_full = (c_aw + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_FIRE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [63+TW:0]      r_mem [DEPTH];
    logic [c_aw-1:0]     r_wr_ptr;
    logic [c_aw-1:0]     r_rd_ptr;
    logic [c_aw:0]       r_count;
    logic [c_aw:0]       w_count_nxt;
    logic [TW-1:0]       r_tnow;
    logic [63:0]         r_command;
    logic                r_cstrobe;
    logic                r_late;
    logic [7:0]          r_coll_cnt;

    logic [63:0]         w_head_cmd;
    logic [TW-1:0]       w_head_time;
    logic [TW-1:0]       w_diff;
    logic                w_due;
    logic                w_late_head;
    logic                w_evaluate;
    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic                w_late_set;

    // Ready is derived from registered occupancy only, so a pop never feeds back.
    assign in_ready    = rst_n & (r_count < c_full);
    assign w_push      = in_valid & in_ready & ~flush;

    assign w_head_cmd  = r_mem[r_rd_ptr][63+TW:TW];
    assign w_head_time = r_mem[r_rd_ptr][TW-1:0];
    // Modular difference read as signed: positive means the stamp has passed.
    assign w_diff      = r_tnow - w_head_time;
    assign w_due       = (w_diff == '0);
    assign w_late_head = ~w_diff[TW-1] & (w_diff != '0);

    always_comb begin
        w_evaluate  = 1'b0;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_late_set  = 1'b0;
        w_count_nxt = r_count;
        w_state_nxt = r_state;

        w_evaluate = (r_state != S_EMPTY) && (r_count != '0) && !flush;
        w_pop      = w_evaluate && (w_due || w_late_head);
        w_late_set = w_evaluate && w_late_head;
`ifdef SCHED_LATE_DROP_EN
        w_issue    = w_evaluate && w_due;
`else
        w_issue    = w_pop;
`endif

        if (flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + (c_aw + 1)'(w_push) - (c_aw + 1)'(w_pop);
        end

        // FIRE re-evaluates the next head so equal stamps issue back to back.
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else if (w_issue) begin
            w_state_nxt = S_FIRE;
        end else if (w_count_nxt != '0) begin
            w_state_nxt = S_WAIT;
        end else begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_cmd, in_time};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tnow     <= '0;
            r_cstrobe  <= 1'b0;
            r_command  <= '0;
            r_late     <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            r_tnow  <= tref_sync ? '0 : r_tnow + TW'(1);
            r_count <= w_count_nxt;

            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end

            r_cstrobe <= w_issue;
            if (w_issue) begin
                r_command <= w_head_cmd;
            end

            if (w_late_set) begin
                r_late <= 1'b1;
            end else if (stat_clr) begin
                r_late <= 1'b0;
            end

            // A clear coinciding with a collision leaves that collision counted.
            if (stat_clr) begin
                r_coll_cnt <= collision ? 8'd1 : 8'd0;
            end else if (collision && (r_coll_cnt != 8'hFF)) begin
                r_coll_cnt <= r_coll_cnt + 8'd1;
            end
        end
    end

    assign command  = r_command;
    assign cstrobe  = r_cstrobe;
    assign tnow     = r_tnow;
    assign level    = r_count;
    assign late     = r_late;
    assign coll_cnt = r_coll_cnt;

endmodule
`default_nettype wire
